// File: rtl/bcd_range_counter.sv
`default_nettype none
// ============================================================================
// bcd_range_counter : N-digit packed-BCD up/down counter with run-time bounds
// Rev 1.0
// ============================================================================
module bcd_range_counter #(
  parameter int                   NDIGITS  = 4,
  parameter logic [4*NDIGITS-1:0] INIT_VAL = 16'h2000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   dir,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   load_val,
  input  logic [4*NDIGITS-1:0]   min_val,
  input  logic [4*NDIGITS-1:0]   max_val,
  output logic [4*NDIGITS-1:0]   value,
  output logic                   wrap,
  output logic                   at_max,
  output logic                   at_min,
  output logic                   load_err,
  output logic                   cfg_err
);

  localparam int W = 4 * NDIGITS;

  logic [W-1:0]       value_q, value_d;
  logic               wrap_q, wrap_d;
  logic               load_err_q, load_err_d;

  logic [NDIGITS-1:0] nines;
  logic [NDIGITS-1:0] zeros;
  logic [NDIGITS-1:0] digit_ok;
  logic [W-1:0]       inc_val;
  logic [W-1:0]       dec_val;
  logic               load_ok;

  // Carry/borrow into a digit is derived directly from the lower digits so the
  // chain is a flat AND rather than a ripple through shared state.
  for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
    logic [3:0] cur;
    logic       cin;
    logic       bin;

    assign cur         = value_q[4*i +: 4];
    assign nines[i]    = (cur >= 4'd9);
    assign zeros[i]    = (cur == 4'd0);
    assign digit_ok[i] = (load_val[4*i +: 4] <= 4'd9);

    if (i == 0) begin : g_lsd
      assign cin = 1'b1;
      assign bin = 1'b1;
    end else begin : g_upper
      assign cin = &nines[i-1:0];
      assign bin = &zeros[i-1:0];
    end

    assign inc_val[4*i +: 4] = !cin ? cur : (nines[i] ? 4'd0 : cur + 4'd1);
    assign dec_val[4*i +: 4] = !bin ? cur : (zeros[i] ? 4'd9 : cur - 4'd1);
  end

  assign cfg_err = (min_val > max_val);
  assign at_max  = (value_q == max_val);
  assign at_min  = (value_q == min_val);
  assign load_ok = (&digit_ok) && (load_val >= min_val) && (load_val <= max_val);

  always_comb begin
    value_d    = value_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_ok) begin
        value_d = load_val;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (en && !cfg_err) begin
      // The >= / <= tests also pull an out-of-range value back after a bounds change.
      if (!dir) begin
        if (value_q >= max_val) begin
          value_d = min_val;
          wrap_d  = 1'b1;
        end else begin
          value_d = inc_val;
        end
      end else begin
        if (value_q <= min_val) begin
          value_d = max_val;
          wrap_d  = 1'b1;
        end else begin
          value_d = dec_val;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q    <= INIT_VAL;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      value_q    <= value_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign value    = value_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule
`default_nettype wire
